reg_file_nport: RTL and testbench



---
 rtl/reg_file_nport.sv | 90 +++++++++
 tb/tb_reg_file_nport.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_nport.sv
// Multi-entry architectural register bank: one byte-masked write port and two
// combinational read ports, with optional hardwired-zero entry and write bypass.
module reg_file_nport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [ADDR_W-1:0]   raddr0,
    output logic [DATA_W-1:0]   rdata0,
    input  logic [ADDR_W-1:0]   raddr1,
    output logic [DATA_W-1:0]   rdata1
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] entry_q [DEPTH];
    logic [DATA_W-1:0] entry_d [DEPTH];
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_ok;
    logic [ADDR_W-1:0] raddr_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];

    assign wr_old = entry_q[waddr];

    // A write commits only when not overridden by clear and not aimed at the zero entry.
    assign wr_ok = we && !clr && !((ZERO_REG != 0) && (waddr == '0));

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign wr_merged[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : wr_old[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (clr) begin
                entry_d[i] = '0;
            end else if (wr_ok && (waddr == ADDR_W'(i))) begin
                entry_d[i] = wr_merged;
            end
        end
        if (ZERO_REG != 0) begin
            entry_d[0] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    assign raddr_arr[0] = raddr0;
    assign raddr_arr[1] = raddr1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd;
            always_comb begin
                rd = entry_q[raddr_arr[gi]];
                if ((BYPASS != 0) && wr_ok && (raddr_arr[gi] == waddr)) begin
                    rd = wr_merged;
                end
                if ((ZERO_REG != 0) && (raddr_arr[gi] == '0)) begin
                    rd = '0;
                end
            end
            assign rdata_arr[gi] = rd;
        end
    endgenerate

    assign rdata0 = rdata_arr[0];
    assign rdata1 = rdata_arr[1];

endmodule

// File: tb/tb_reg_file_nport.sv
// Randomised and directed checks of reg_file_nport in two configurations
// (zero-reg + bypass, and plain) against an array-based reference model.
`timescale 1ns/100ps
module tb_reg_file_nport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [4:0]  raddr0 = '0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;

    int total = 0;
    int bad = 0;

    // Model index 0: ZERO_REG=1 BYPASS=1; index 1: ZERO_REG=0 BYPASS=0.
    logic [31:0] mdl [2][32];

    always #5 clk = ~clk;

    reg_file_nport #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .raddr0(raddr0), .rdata0(rd0_a), .raddr1(raddr1), .rdata1(rd1_a)
    );

    reg_file_nport #(.DATA_W(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .raddr0(raddr0), .rdata0(rd0_b), .raddr1(raddr1), .rdata1(rd1_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        if (c == 0 && a == 5'd0) return 32'd0;
        if (c == 0 && we && !clr && a == waddr) return merge(mdl[c][a]);
        return mdl[c][a];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 32; a++)
                mdl[c][a] = 32'd0;
    endtask

    task automatic model_edge();
        if (clr) begin
            model_clear();
        end else if (we) begin
            for (int c = 0; c < 2; c++)
                if (!(c == 0 && waddr == 5'd0)) mdl[c][waddr] = merge(mdl[c][waddr]);
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_a0"}, rd0_a, exp_rd(0, raddr0));
        check({tag, "_a1"}, rd1_a, exp_rd(0, raddr1));
        check({tag, "_b0"}, rd0_b, exp_rd(1, raddr0));
        check({tag, "_b1"}, rd1_b, exp_rd(1, raddr1));
    endtask

    task automatic tick();
        @(posedge clk);
        $display("t=%0t we=%0b clr=%0b waddr=%0d wdata=%h wstrb=%h", $time, we, clr, waddr, wdata, wstrb);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
        #1 check_reads("wr");
        tick();
        we = 1'b0;
    endtask

    logic [31:0] fill_vals [5];

    initial begin
        model_clear();
        fill_vals[0] = 32'h0000_000A; fill_vals[1] = 32'h0000_0014; fill_vals[2] = 32'h0000_0064;
        fill_vals[3] = 32'h0000_0080; fill_vals[4] = 32'h0000_2000;

        // Reset
        #2 check("rst_hold", rd0_b, 32'd0);
        #5 rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(31 - a);
            #0.5 check_reads("rst");
        end
        @(posedge clk); #1;

        // Sequential fill
        for (int i = 0; i < 5; i++) wr(5'(i + 1), 32'(10 * (i == 0) + 20 * (i == 1) + 100 * (i == 2) + 128 * (i == 3) + 8192 * (i == 4)), 4'hF);
        for (int i = 0; i < 5; i++) begin
            raddr0 = 5'(i + 1); raddr1 = 5'(i + 1);
            #1;
            check("fill_a0", rd0_a, fill_vals[i]);
            check("fill_a1", rd1_a, fill_vals[i]);
            check("fill_b0", rd0_b, fill_vals[i]);
            check("fill_b1", rd1_b, fill_vals[i]);
        end

        // Byte mask
        wr(5'd3, 32'h1122_3344, 4'hF);
        wr(5'd3, 32'hAABB_CCDD, 4'b0101);
        raddr0 = 5'd3; #1;
        check("bmask_a", rd0_a, 32'h11BB_33DD);
        check("bmask_b", rd0_b, 32'h11BB_33DD);
        wr(5'd3, 32'hFFFF_FFFF, 4'h0);
        check("nostrb", rd0_b, 32'h11BB_33DD);

        // Zero register
        wr(5'd0, 32'hDEAD_BEEF, 4'hF);
        raddr0 = 5'd0; raddr1 = 5'd0; #1;
        check("zr_on", rd0_a, 32'd0);
        check("zr_on1", rd1_a, 32'd0);
        check("zr_off", rd0_b, 32'hDEAD_BEEF);

        // Bypass
        wr(5'd7, 32'd5, 4'hF);
        raddr0 = 5'd7; raddr1 = 5'd7;
        we = 1'b1; waddr = 5'd7; wdata = 32'd100; wstrb = 4'hF;
        #1;
        check("byp_on", rd0_a, 32'd100);
        check("byp_off", rd0_b, 32'd5);
        check_reads("byp");
        tick();
        we = 1'b0; #1;
        check("byp_after_a", rd0_a, 32'd100);
        check("byp_after_b", rd0_b, 32'd100);

        // Clear with coincident write; bypass suppressed
        wr(5'd2, 32'd55, 4'hF);
        clr = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'd20; wstrb = 4'hF; raddr0 = 5'd2;
        #1;
        check("clr_nobyp", rd0_a, 32'd55);
        check_reads("clr_pre");
        tick();
        clr = 1'b0; we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(a);
            #0.1 check("clr_zero", rd0_b, 32'd0);
        end
        check_reads("clr_post");

        // Refill, then async reset pulse between edges
        @(posedge clk); #1;
        wr(5'd9, 32'h1234_5678, 4'hF);
        wr(5'd4, 32'hCAFE_F00D, 4'hF);
        raddr0 = 5'd9; raddr1 = 5'd4; #1;
        check("refill", rd0_a, 32'h1234_5678);
        rst = 1'b1; model_clear();
        #0.5;
        check("arst_a0", rd0_a, 32'd0);
        check("arst_b1", rd1_b, 32'd0);
        check_reads("arst");
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            raddr0 = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1 check_reads("rnd");
            tick();
        end
        we = 1'b0; clr = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(31 - a);
            #0.2 check_reads("final");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
